fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage. Sits directly upstream of decode.
//  Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
//  Delivers {instr, pc} to decode over a valid/ready handshake. Decode latches instr_o when it accepts.
//  Handles pipeline redirects (branch/jump) by flushing buffered and in-flight instructions.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC of the first fetch after reset
//  PC_STEP    4               PC increment per sequential fetch (bytes)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   reset, asynchronous, active-low
//  imem_req_o       out  1   request to instruction memory
//  imem_addr_o      out  32  request address, word aligned
//  imem_gnt_i       in   1   memory accepted request this cycle
//  imem_rvalid_i    in   1   read data valid (in order, >=1 cycle after gnt)
//  imem_rdata_i     in   32  instruction word
//  redirect_i       in   1   redirect PC (from execute), single-cycle pulse
//  redirect_pc_i    in   32  redirect target
//  instr_valid_o    out  1   instr_o/pc_o valid to decode
//  instr_ready_i    in   1   decode accepts this cycle
//  instr_o          out  32  instruction to decode
//  pc_o             out  32  PC of instr_o
//  fetch_fault_o    out  1   misaligned redirect fault (only with FETCH_MISALIGN_CHECK_EN)
// BEHAVIOUR
//  Reset: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=NOP (32'h0000_0013),
//    pc_o=0, fetch_fault_o=0, state=IDLE, skid empty, drop flag clear.
//  FSM states:
//   - IDLE: go to REQ next cycle. First req is 1 cycle after reset release.
//   - REQ: imem_req_o=1; addr/req held stable until gnt. On gnt -> WAIT, pc_q += PC_STEP.
//   - WAIT: no new req. On rvalid -> REQ if slot capacity remains, else STALL.
//   - STALL: output reg and skid both full. -> REQ once decode accepts.
//   - FAULT: entered only with FETCH_MISALIGN_CHECK_EN.
//  At most one outstanding request.
//  REQ asserted only if skid is empty. The response returns into the output reg when it is free or
//    being accepted this cycle; otherwise it goes to the 1-entry skid.
//  Latency: rvalid in cycle t -> instr_valid_o in t+1. Peak throughput 1 instr per 2 cycles.
//  Handshake: instr_valid_o, instr_o and pc_o are held stable until instr_valid_o && instr_ready_i.
//    After acceptance, the skid entry (if any) moves to the output reg next cycle.
//  Redirect priority: redirect_i wins over all other events in the same cycle.
//   - Clears instr_valid_o and skid next cycle. pc_q <= {redirect_pc_i[31:2],2'b00}.
//   - If a request is outstanding (WAIT, or gnt in the same cycle), set drop; the next rvalid is
//     discarded and drop clears.
//   - New REQ to the target is issued the cycle after redirect when nothing is outstanding.
//     Otherwise it is issued the cycle after the dropped rvalid.
//   - Redirect in REQ without gnt: the address switches to the target next cycle (ungranted request
//     may change).
//  Simultaneous rvalid and instr_ready_i with a full output reg: the new word enters the output reg
//    directly. No bubble, skid unused.
//  PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
//  Async reset mid-transaction: all state cleared. A late rvalid after reset is ignored unless in
//    WAIT.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//   - redirect_pc_i[1:0] != 0 -> FAULT and fetch_fault_o=1 (registered). No req issued.
//   - An outstanding response is still dropped.
//   - Only the next aligned redirect leaves FAULT (-> REQ) and clears fetch_fault_o.
//  Not defined: fetch_fault_o tied 0, redirect_pc_i[1:0] ignored, FAULT state absent.
// STRUCTURE
//  riscv_pkg:
//   - NOP_INSTR = 32'h0000_0013
//   - typedef enum logic [2:0] fetch_state_e {IDLE, REQ, WAIT, STALL, FAULT}
//   - typedef struct packed fetch_pkt_t {logic [31:0] instr; logic [31:0] pc;}
//  Sub-module fetch_skid_buf:
//   - 1-entry fetch_pkt_t holding register with valid, push/pop, flush
//   - Instantiated once
// TESTING
//  1. Reset release, gnt same cycle, rvalid 1 cycle later, ready=1:
//     addr 0,4,8 issued; decode sees pc_o 0,4,8 and instr = rdata.
//  2. ready=0 for 6 cycles:
//     - instr at pc 0 held stable; pc 4 goes to skid; no req while skid full.
//     - When ready rises: pc 0 then pc 4 delivered back-to-back.
//  3. Redirect to 32'h100 while in WAIT (pc 8 outstanding):
//     pc 8 rvalid dropped; next instr_valid_o has pc_o=32'h100; no pc 8 delivered.
//  4. Redirect same cycle as instr_valid_o && instr_ready_i and a skid entry:
//     both flushed; instr_valid_o=0 next cycle; req addr=target.
//  5. Redirect to 32'hFFFF_FFFC, 2 fetches: pcs FFFF_FFFC then 0000_0000.
//  6. With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102:
//     fetch_fault_o=1, no req for 10 cycles; redirect to 32'h200 clears the fault, fetch resumes at 200.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: state encoding, decode packet and the reset NOP.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    STALL = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched packet that arrives while the
// output register is full and not being accepted.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output logic       valid,
  output fetch_pkt_t pkt
);

  // flush beats push beats pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pkt   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      pkt   <= push_pkt;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, output reg + skid to decode.
// Optional misaligned-redirect fault via `define FETCH_MISALIGN_CHECK_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fetch_fault_o
);

  fetch_state_e state;
  fetch_state_e redirect_state;
  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc;
  logic         drop_q;
  logic         out_valid;
  fetch_pkt_t   out_pkt;

  logic         skid_valid;
  fetch_pkt_t   skid_pkt;
  logic         skid_push;
  logic         skid_pop;

  logic         grant;
  logic         accept;
  logic         resp;
  logic         outstanding_after;
  fetch_pkt_t   resp_pkt;

  assign imem_req_o    = (state == REQ) && !skid_valid;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = out_valid;
  assign instr_o       = out_pkt.instr;
  assign pc_o          = out_pkt.pc;

  assign grant    = imem_req_o && imem_gnt_i;
  assign accept   = out_valid && instr_ready_i;
  assign resp     = imem_rvalid_i && (state == WAIT) && !drop_q;
  assign resp_pkt = '{instr: imem_rdata_i, pc: inflight_pc};

  // A response still owed after this cycle: one waiting, or one granted now.
  assign outstanding_after = (((state == WAIT) || drop_q) && !imem_rvalid_i) || grant;

  assign skid_push = resp && out_valid && !instr_ready_i && !redirect_i;
  assign skid_pop  = accept && skid_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  logic fault_q;

  assign misaligned    = |redirect_pc_i[1:0];
  assign fetch_fault_o = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fault_q <= 1'b0;
    else if (redirect_i) fault_q <= misaligned;
  end

  always_comb begin
    redirect_state = outstanding_after ? WAIT : REQ;
    if (misaligned) redirect_state = FAULT;
  end
`else
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign fetch_fault_o = 1'b0;

  always_comb begin
    redirect_state = outstanding_after ? WAIT : REQ;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      inflight_pc <= RESET_PC;
      drop_q      <= 1'b0;
    end else if (redirect_i) begin
      state  <= redirect_state;
      pc_q   <= word_align(redirect_pc_i);
      drop_q <= outstanding_after;
    end else begin
      if (imem_rvalid_i && drop_q) drop_q <= 1'b0;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (grant) begin
            inflight_pc <= pc_q;
            pc_q        <= pc_q + PC_STEP;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) state <= skid_push ? STALL : REQ;
        end
        STALL: begin
          if (accept) state <= REQ;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        FAULT: state <= FAULT;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // A response lands in the output reg whenever it is free or draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pkt   <= '{instr: NOP_INSTR, pc: 32'h0};
    end else if (redirect_i) begin
      out_valid <= 1'b0;
    end else if (resp && (!out_valid || instr_ready_i)) begin
      out_valid <= 1'b1;
      out_pkt   <= resp_pkt;
    end else if (accept) begin
      if (skid_valid) out_pkt <= skid_pkt;
      out_valid <= skid_valid;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (skid_push),
    .push_pkt (resp_pkt),
    .pop      (skid_pop),
    .flush    (redirect_i),
    .valid    (skid_valid),
    .pkt      (skid_pkt)
  );

endmodule
